uart_rx_sampler: RTL and testbench
==================================

# uart_rx_sampler

Serial-to-parallel UART receiver for the CPU's peripheral bus: 8 data bits, no parity, 1 stop bit, LSB first. It samples the asynchronous `UART_RX` line on `sysclk` and presents each received byte in a holding register with a valid flag. It also reports framing errors and overruns. It sits between the board's `UART_RX` pin and the CPU's UART data/status registers, and receives the same frames the CPU testbench drives onto `UART_RX`.

## Interface
Parameters:
- `CLKS_PER_BIT`, 10416, sysclk cycles per bit (100 MHz / 9600 baud); legal minimum 4.
- `HALF` (localparam), `CLKS_PER_BIT/2` (integer divide).

Ports:
- `sysclk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `UART_RX` in 1: asynchronous serial line; idles high.
- `rx_data` out 8: last good byte.
- `rx_valid` out 1: `rx_data` holds an unread byte.
- `frame_err` out 1: sticky; a frame had a 0 stop bit.
- `overrun` out 1: sticky; a byte was loaded while `rx_valid` was already 1.
- `rx_ack` in 1: one-cycle read pulse from the bus.

## Operation
- Input synchronizer: 2 flops, both reset to 1. `rxs` is the second flop's output.
- Bit counter `cnt`: 0..`CLKS_PER_BIT`-1. Bit index `idx`: 0..7. Shift register `sh[7:0]`.
- FSM, reset state IDLE:
  - IDLE: on `rxs`==0, go to START with `cnt`=0.
  - START: count to `HALF`-1. At `cnt`==`HALF`-1, sample:
    - 0: go to DATA with `cnt`=0, `idx`=0.
    - 1: glitch; go to IDLE.
  - DATA: at `cnt`==`CLKS_PER_BIT`-1, shift the sample into `sh[7]` (right shift, so LSB first) and reset `cnt`. After `idx`==7 is sampled, go to STOP.
  - STOP: at `cnt`==`CLKS_PER_BIT`-1, sample:
    - 1: load `rx_data`<=`sh`, set `rx_valid`=1, go to IDLE. This happens at mid-stop-bit, so a back-to-back start bit is caught.
    - 0: set `frame_err`=1, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: on `rxs`==1, go to IDLE. A held-low (break) line does not retrigger.
- Flag rules:
  - `rx_ack` clears `rx_valid`, `overrun` and `frame_err`.
  - Set beats clear in the same cycle.
  - A load in the same cycle as `rx_ack` sets `rx_valid`=1 and leaves `overrun` unchanged (no overrun).
  - A load while `rx_valid`=1 and no `rx_ack` overwrites `rx_data` and sets `overrun`=1.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial byte is lost.
  - The first frame after deassertion is received only if the synchronizer sees a high-to-low transition on the line.
  - Reset released while `UART_RX` is low enters IDLE, which starts on the low level; a START-phase sample of 0 is accepted. This is a documented behaviour, not an error.

## Timing
- Reset values: `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0, synchronizer=2'b11, `cnt`=0, `idx`=0, FSM=IDLE.
- Let edge E be the first `sysclk` edge at which the first synchronizer flop captures the start bit's 0.
  - `rxs` goes low after edge E+1.
  - IDLE leaves at edge E+2.
  - The START sample is taken at edge E+2+`HALF`.
  - Data bit i is sampled at edge E+2+`HALF`+(i+1)·`CLKS_PER_BIT`.
  - The stop bit is sampled at edge E+2+`HALF`+9·`CLKS_PER_BIT`. `rx_valid` and `rx_data` are visible after that edge.
- Receive latency from start-bit edge to `rx_valid`: `HALF`+9·`CLKS_PER_BIT`+3 cycles, up to ±1 cycle of synchronizer phase.
- `rx_ack` takes effect at the next edge; `rx_valid` is low one cycle after the pulse.
- Counters never wrap outside their ranges; `cnt` is sized to $clog2(`CLKS_PER_BIT`).

## Configuration
- Macro `UART_RX_MAJORITY_EN`.
- Defined:
  - A 3-bit history `h` of `rxs` is kept, reset to 3'b111.
  - Every sample point (START, DATA, STOP) uses majority(`h[2:0]`), computed from the current `rxs` and the two previous cycles.
  - A 1-cycle glitch at a sample point is rejected. Latency is unchanged.
- Undefined: every sample is the single `rxs` value at the sample edge.

## Test plan
Run with `CLKS_PER_BIT`=16 unless noted.
1. Reset: drive `reset`=0 with `UART_RX` toggling -> `rx_data`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0. After release with the line idle high, no `rx_valid` appears.
2. Single byte: send 8'h55 (start 0, alternating bits, stop 1) -> `rx_data`=8'h55, `rx_valid`=1 exactly `HALF`+9·16+3=155±1 cycles after the start edge. `rx_ack` -> `rx_valid`=0 next cycle.
3. Glitch start: `UART_RX` low for 4 cycles then high -> START samples 1 and returns to IDLE. No `rx_valid`, no `frame_err`.
4. Framing/break: send 8'hA5 with stop bit 0, then hold the line low for 40 bit times -> `frame_err`=1, `rx_valid`=0, FSM stays in WAIT_HIGH. After the line goes high, 8'h3C is received correctly.
5. Overrun: send 8'h12 then 8'h34 back-to-back, no ack -> `rx_data`=8'h34, `overrun`=1. Repeat with `rx_ack` on the second load cycle -> `rx_valid`=1, `overrun`=0.
6. Mid-frame reset, then majority mode:
   - Assert `reset` during data bit 3, release, send 8'hC3 -> `rx_data`=8'hC3 with no stale bits.
   - With `UART_RX_MAJORITY_EN` defined, inject a 1-cycle inversion at each data-bit sample point of 8'hF0 -> received byte is 8'hF0.
   - Without the macro, the same stimulus yields 8'h0F.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: samples UART_RX at mid-bit and holds the last byte with valid/overrun/framing flags.
// Optional build macro UART_RX_MAJORITY_EN: 3-sample majority vote at every sample point.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  input  logic       rx_ack
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            rxs;
  logic            sample;
  logic            load;
  logic            ferr_set;

  assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
  // h_q holds the two previous rxs values; the vote window is {previous two, current}.
  logic [1:0] h_q;
  logic [2:0] h;
  assign h      = {h_q, rxs};
  assign sample = (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) h_q <= 2'b11;
    else        h_q <= h[1:0];
  end
`else
  assign sample = rxs;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], UART_RX};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    load     = 1'b0;
    ferr_set = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sample ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = {sample, sh_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Decide at mid-stop-bit so an immediately following start bit is not missed.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (sample) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Setting a flag wins over an acknowledge in the same cycle.
    rx_data_d   = load ? sh_q : rx_data_q;
    rx_valid_d  = load | (rx_valid_q & ~rx_ack);
    overrun_d   = (load & rx_valid_q & ~rx_ack) | (overrun_q & ~rx_ack);
    frame_err_d = ferr_set | (frame_err_q & ~rx_ack);
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler at 16 clocks per bit; expectations are hand-derived frame timings.
module tb_uart_rx_sampler;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
  // Start bit driven just after edge T0 -> byte visible just after edge T0 + LAT.
  localparam int LAT  = HALF + 9 * CPB + 3;

  logic       sysclk;
  logic       reset;
  logic       UART_RX;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_ack;

  int vectors;
  int miscompares;

  uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .UART_RX  (UART_RX),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_ack   (rx_ack)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic wait_clk();
    @(posedge sysclk);
    #1;
  endtask

  // Drives one 8N1 frame. With glitch set, each data bit is inverted for the
  // single line cycle that lands on the DUT's sample point.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic glitch);
    UART_RX = 1'b0;
    repeat (CPB) wait_clk();
    for (int i = 0; i < 8; i++) begin
      for (int k = 1; k <= CPB; k++) begin
        UART_RX = (glitch && k == HALF + 1) ? ~b[i] : b[i];
        wait_clk();
      end
    end
    UART_RX = stop_bit;
    repeat (CPB) wait_clk();
    $display("tx frame byte=%02h stop=%0d glitch=%0d", b, stop_bit, glitch);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    wait_clk();
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      UART_RX = i[0];
      wait_clk();
    end
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data got=%02h want=00", rx_data); end
    vectors++;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    UART_RX = 1'b1;
    wait_clk();
    reset = 1'b1;
    repeat (200) wait_clk();
    vectors++;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset got=%b want=0", rx_valid); end
    $display("reset test done");
  endtask

  task automatic test_single_byte();
    fork
      send_byte(8'h55, 1'b1, 1'b0);
      begin
        repeat (LAT - 1) wait_clk();
        vectors++;
        if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early got=%b want=0", rx_valid); end
        wait_clk();
        vectors++;
        if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL latency_valid got=%b want=1", rx_valid); end
        vectors++;
        if (rx_data !== 8'h55) begin miscompares++; $display("FAIL byte_55 got=%02h want=55", rx_data); end
      end
    join
    repeat (4) wait_clk();
    pulse_ack();
    vectors++;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL ack_clears_valid got=%b want=0", rx_valid); end
  endtask

  task automatic test_glitch_start();
    UART_RX = 1'b0;
    repeat (4) wait_clk();
    UART_RX = 1'b1;
    repeat (200) wait_clk();
    vectors++;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid got=%b want=0", rx_valid); end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL glitch_frame_err got=%b want=0", frame_err); end
    $display("glitch start applied");
  endtask

  task automatic test_framing_break();
    send_byte(8'hA5, 1'b0, 1'b0);
    repeat (40 * CPB) wait_clk();
    vectors++;
    if (frame_err !== 1'b1) begin miscompares++; $display("FAIL break_frame_err got=%b want=1", frame_err); end
    vectors++;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL break_valid got=%b want=0", rx_valid); end
    UART_RX = 1'b1;
    repeat (2 * CPB) wait_clk();
    send_byte(8'h3C, 1'b1, 1'b0);
    repeat (4) wait_clk();
    vectors++;
    if (rx_data !== 8'h3C) begin miscompares++; $display("FAIL after_break_data got=%02h want=3c", rx_data); end
    vectors++;
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL after_break_valid got=%b want=1", rx_valid); end
    vectors++;
    if (frame_err !== 1'b1) begin miscompares++; $display("FAIL frame_err_sticky got=%b want=1", frame_err); end
    pulse_ack();
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL ack_clears_frame_err got=%b want=0", frame_err); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    repeat (4) wait_clk();
    vectors++;
    if (rx_data !== 8'h34) begin miscompares++; $display("FAIL overrun_data got=%02h want=34", rx_data); end
    vectors++;
    if (overrun !== 1'b1) begin miscompares++; $display("FAIL overrun_set got=%b want=1", overrun); end
    pulse_ack();
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL ack_clears_overrun got=%b want=0", overrun); end
    repeat (4) wait_clk();
    fork
      begin
        send_byte(8'h12, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
      end
      begin
        // Second load edge is one frame (10 bits) after the first.
        repeat (10 * CPB + LAT - 1) wait_clk();
        rx_ack = 1'b1;
        wait_clk();
        rx_ack = 1'b0;
        vectors++;
        if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL load_with_ack_valid got=%b want=1", rx_valid); end
        vectors++;
        if (overrun !== 1'b0) begin miscompares++; $display("FAIL load_with_ack_overrun got=%b want=0", overrun); end
        vectors++;
        if (rx_data !== 8'h34) begin miscompares++; $display("FAIL load_with_ack_data got=%02h want=34", rx_data); end
      end
    join
    repeat (4) wait_clk();
  endtask

  task automatic test_midframe_reset();
    // rx_valid is still 1 from the previous test; reset must drop it at once.
    UART_RX = 1'b0;
    repeat (CPB + 3 * CPB + HALF) wait_clk();
    reset = 1'b0;
    #1;
    vectors++;
    if (rx_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_valid got=%b want=0", rx_valid); end
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL async_reset_data got=%02h want=00", rx_data); end
    UART_RX = 1'b1;
    repeat (3) wait_clk();
    reset = 1'b1;
    repeat (10) wait_clk();
    send_byte(8'hC3, 1'b1, 1'b0);
    repeat (4) wait_clk();
    vectors++;
    if (rx_data !== 8'hC3) begin miscompares++; $display("FAIL post_reset_data got=%02h want=c3", rx_data); end
    vectors++;
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL post_reset_valid got=%b want=1", rx_valid); end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL post_reset_frame_err got=%b want=0", frame_err); end
    pulse_ack();
  endtask

  task automatic test_majority();
    logic [7:0] want;
`ifdef UART_RX_MAJORITY_EN
    want = 8'hF0;
`else
    want = 8'h0F;
`endif
    repeat (4) wait_clk();
    send_byte(8'hF0, 1'b1, 1'b1);
    repeat (4) wait_clk();
    vectors++;
    if (rx_data !== want) begin miscompares++; $display("FAIL sample_glitch_data got=%02h want=%02h", rx_data, want); end
    vectors++;
    if (rx_valid !== 1'b1) begin miscompares++; $display("FAIL sample_glitch_valid got=%b want=1", rx_valid); end
    pulse_ack();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    UART_RX     = 1'b1;
    rx_ack      = 1'b0;
    wait_clk();
    test_reset();
    test_single_byte();
    test_glitch_start();
    test_framing_break();
    test_back_to_back();
    test_midframe_reset();
    test_majority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
